adc_ser_ctrl: RTL

Parametrised serial-ADC conversion controller for the sig_acq acquisition front end. It drives the convert-start / chip-select / frame-sync / serial-clock sequence for N_CH ADCs that share one timing bus. It waits for the ADCs' end-of-conversion interrupts, then shifts in DATA_W bits per channel, MSB first. Results are presented as one parallel word with a valid/ready handshake, plus overrun and timeout reporting.

---
 rtl/adc_ser_if.sv | 28 ++
 rtl/adc_ser_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/adc_ser_if.sv
// adc_ser_if: timing bus, ADC inputs and result handshake of the serial ADC controller
interface adc_ser_if #(
  parameter int DATA_W = 14,
  parameter int N_CH = 2
);
  logic ena;
  logic start;
  logic [N_CH-1:0] int_n;
  logic [N_CH-1:0] sdi;
  logic cstart_n;
  logic cs_n;
  logic fs;
  logic sclk;
  logic [N_CH*DATA_W-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic overrun;
  logic err_timeout;
  logic busy;
  modport master (
    input ena, start, int_n, sdi, dout_ready,
    output cstart_n, cs_n, fs, sclk, dout, dout_valid, overrun, err_timeout, busy
  );
  modport slave (
    output ena, start, int_n, sdi, dout_ready,
    input cstart_n, cs_n, fs, sclk, dout, dout_valid, overrun, err_timeout, busy
  );
endinterface

// File: rtl/adc_ser_ctrl.sv
// adc_ser_ctrl: serial ADC conversion sequencer with parallel result handshake
module adc_ser_ctrl #(
  parameter int DATA_W = 14,
  parameter int N_CH = 2,
  parameter int SCLK_DIV = 4,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  adc_ser_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(SCLK_DIV) + 1;
  typedef enum logic [2:0] {IDLE, CONV, FRAME, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] meta_q, sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [DATA_W-1:0] sh_q [N_CH];
  logic [DATA_W-1:0] sh_d [N_CH];
  logic [N_CH*DATA_W-1:0] dout_q, dout_d;
  logic valid_q, valid_d, ovr_q, ovr_d;
  logic cstart_n_q, cs_n_q, fs_q, sclk_q, busy_q;
  logic all_eoc, eoc_ok, timeout, fall, hs, on_q, on_d;
  always_comb begin
    all_eoc = ~|sync_q;
    fall = int'(div_q) == 2 * SCLK_DIV - 1;
    eoc_ok = state_q == CONV && int'(cnt_q) >= SCLK_DIV && all_eoc;
    timeout = state_q == CONV && int'(cnt_q) == TIMEOUT - 1 && !eoc_ok;
    hs = valid_q && bus.dout_ready;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.start && bus.ena ? CONV : IDLE;
      CONV: state_d = eoc_ok ? FRAME : timeout ? IDLE : CONV;
      FRAME: state_d = fall ? SHIFT : FRAME;
      SHIFT: state_d = fall && int'(bit_q) == DATA_W - 1 ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
    on_q = state_q == FRAME || state_q == SHIFT;
    on_d = state_d == FRAME || state_d == SHIFT;
    cnt_d = state_q == CONV && state_d == CONV ? cnt_q + CW'(1) : '0;
    div_d = on_q && on_d && !fall ? div_q + DW'(1) : '0;
    bit_d = state_q == SHIFT && state_d == SHIFT ? bit_q + BW'(fall) : '0;
    dout_d = dout_q;
    // bits are captured on the clk edge that drops sclk, MSB first
    for (int k = 0; k < N_CH; k++) begin
      sh_d[k] = state_q == SHIFT && fall ? {sh_q[k][DATA_W-2:0], bus.sdi[k]} : sh_q[k];
      if (state_q == DONE) dout_d[k*DATA_W +: DATA_W] = sh_q[k];
    end
    valid_d = state_q == DONE || (valid_q && !hs);
    ovr_d = !hs && (ovr_q || (state_q == DONE && valid_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      meta_q <= '1;
      sync_q <= '1;
      cnt_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      sh_q <= '{default: '0};
      dout_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      cstart_n_q <= 1'b1;
      cs_n_q <= 1'b1;
      fs_q <= 1'b0;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q <= bus.int_n;
      sync_q <= meta_q;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      div_q <= div_d;
      sh_q <= sh_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      cstart_n_q <= !(state_d == CONV && int'(cnt_d) < SCLK_DIV);
      cs_n_q <= !on_d;
      fs_q <= state_d == FRAME;
      sclk_q <= on_d && int'(div_d) >= SCLK_DIV;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.cstart_n = cstart_n_q;
  assign bus.cs_n = cs_n_q;
  assign bus.fs = fs_q;
  assign bus.sclk = sclk_q;
  assign bus.dout = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.overrun = ovr_q;
  assign bus.err_timeout = timeout;
  assign bus.busy = busy_q;
endmodule
